four_mux_rr_arbiter: RTL
========================

Name: four_mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux path between four requesters.
- Drives the mux's 2-bit select and returns a one-hot grant to each requester.
- A bounded hold timer lets an owner keep the path for several cycles, but never starves the other requesters.
- Sits directly in front of the 4:1 mux; sel connects straight to its select input.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one owner keeps the grant while another requester waits; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i is requester i; level-sensitive, held high while access is wanted.
- gnt  output 4  one-hot grant, registered; all zero when idle.
- sel  output 2  mux select (index of the owner), registered.
- busy output 1  high while any grant is active, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, gnt=4'b0000, sel=2'd0, busy=0, hold_cnt=0.
  - last_ptr=2'd3, so requester 0 has first priority after reset.
- States: IDLE, GRANT.
- Pick function: search order last_ptr+1, +2, +3, +4 (mod 4); the first set bit of the candidate vector wins.
- IDLE:
  - If req==0: stay in IDLE; outputs unchanged.
  - Otherwise, at that edge: winner w = pick(req); gnt=1<<w, sel=w, busy=1, last_ptr=w, hold_cnt=1; go to GRANT.
  - Latency: req seen at edge N gives gnt valid after edge N (one clock).
- GRANT (owner o = sel):
  - (a) req[o]==0 and other requests pending: re-arbitrate at the same edge with no idle bubble. New winner w = pick(req) (o is excluded because its req bit is low). Update gnt/sel/last_ptr; hold_cnt=1.
  - (b) req[o]==0 and no other requests: go to IDLE. gnt=0, busy=0, hold_cnt=0. sel holds its last value.
  - (c) req[o]==1, hold_cnt>=HOLD_MAX, and req & ~(1<<o) != 0: preempt. Pick among the other requesters only; update gnt/sel/last_ptr; hold_cnt=1.
  - (d) req[o]==1, otherwise: keep the grant. hold_cnt increments and saturates at HOLD_MAX. An uncontended owner keeps the grant indefinitely.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]==busy.
  - sel changes only on a grant change.
- Simultaneous events:
  - A new request arriving on the same edge the owner releases takes part in that edge's arbitration.
  - All four requesting at once rotate 0,1,2,3,0…, each served for HOLD_MAX cycles.
- HOLD_MAX=1 with contention: the grant rotates every cycle.
- Reset asserted mid-grant: outputs clear immediately and asynchronously. After deassertion the block restarts from IDLE with last_ptr=3.
- The mux data path is not registered by this block. Mux output is valid in any cycle where busy=1, for requester sel.

Decomposition:
- Shared package/include holds:
  - N_REQ=4, SEL_W=2.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
- One natural sub-module, rr_pick4: purely combinational.
  - Inputs: cand[3:0], last_ptr[1:0].
  - Outputs: idx[1:0], found.
  - Used for both normal arbitration and preemption (cand = req & ~(1<<o)).
- Top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset then single request: rst pulse, then req=4'b0100 held → after 1 edge gnt=4'b0100, sel=2, busy=1. Grant is held indefinitely (no preemption); hold_cnt saturates at 4.
- Release with no contention: owner 2 drops req → next edge gnt=0, busy=0, sel stays 2. Then req=4'b0001 → gnt=4'b0001, sel=0.
- Fairness with HOLD_MAX=4: req=4'b1111 held from IDLE after reset → grant sequence 0,1,2,3,0, each exactly 4 cycles; gnt is always one-hot.
- Back-to-back handoff: owner 1 deasserts on the same edge that req[3] is high and req[0] is high → next gnt=4'b1000 (search starts after 1); no IDLE cycle, busy stays 1.
- Preemption: HOLD_MAX=2; owner 0 holds req, req[2] rises at cycle 5 → the grant moves to 2 on the first edge where hold_cnt>=2. Requester 0 is regranted only after 2 releases or is preempted.
- Async reset mid-grant: assert rst between edges while gnt=4'b0010 → gnt=0, busy=0, sel=0 immediately (before the next edge). After release, req=4'b1010 → gnt=4'b0010 (last_ptr reset to 3).

Source files
------------

// File: rtl/four_mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-way round-robin
// arbiter that fronts a 4:1 single-bit mux.
package four_mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/four_mux_rr_arbiter_rr_pick4.sv
// Rotating priority pick: first set bit of i_cand searching from
// i_last_ptr+1 upward, modulo four.
module rr_pick4
  import four_mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_cand,
  input  logic [SEL_W-1:0] i_last_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  logic [SEL_W-1:0] w_try;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_try   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_try = i_last_ptr + SEL_W'(k);
      if (!o_found && i_cand[w_try]) begin
        o_idx   = w_try;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time; drives the shared mux
// select and a one-hot grant back to the four requesters.
module four_mux_rr_arbiter
  import four_mux_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(HOLD_MAX);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic [SEL_W-1:0] r_last;
  logic [CNT_W-1:0] r_hold;

  state_t           w_state_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_busy_nxt;
  logic [SEL_W-1:0] w_last_nxt;
  logic [CNT_W-1:0] w_hold_nxt;

  logic             w_own;
  logic [N_REQ-1:0] w_others;
  logic [N_REQ-1:0] w_cand;
  logic             w_hold_done;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;
  logic             w_take;

  assign w_own       = req[r_sel];
  assign w_others    = req & ~(ONE << r_sel);
  assign w_hold_done = (r_hold >= HMAX);
  // A holding owner only ever competes against the others.
  assign w_cand = (r_state == ST_GRANT && w_own) ? w_others : req;

  rr_pick4 u_pick (
    .i_cand    (w_cand),
    .i_last_ptr(r_last),
    .o_idx     (w_idx),
    .o_found   (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_last  <= SEL_W'(N_REQ - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_take      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) w_take = 1'b1;
      end
      ST_GRANT: begin
        if (!w_own) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_hold_nxt  = '0;
          end
        end else if (w_hold_done && |w_others) begin
          w_take = 1'b1;
        end else if (!w_hold_done) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
    endcase
    if (w_take) begin
      w_state_nxt = ST_GRANT;
      w_gnt_nxt   = ONE << w_idx;
      w_sel_nxt   = w_idx;
      w_busy_nxt  = 1'b1;
      w_last_nxt  = w_idx;
      w_hold_nxt  = CNT_W'(1);
    end
  end

  always_comb begin
    gnt  = r_gnt;
    sel  = r_sel;
    busy = r_busy;
  end

endmodule
